// File: rtl/peridot_cam_frame_seq.sv
// Frame capture sequencer: arms on vsync, loads/launches the camera burst master, raises irq on completion.
// Latency: vsync N -> fifo_flush N+1, cam_start N+2; cam_done rise M -> irq M+2. No backpressure: CSR zero-wait.
// Define PERIDOT_CAM_SEQ_PINGPONG_EN to alternate BUF_A/BUF_B per frame; otherwise every frame uses BUF_A.
`timescale 1ns/1ps
module peridot_cam_frame_seq #(
  parameter logic [15:0] CHUNKS_DEFAULT = 16'd9600
) (
  input  logic        avs_s1_clk,
  input  logic        csi_global_reset_n,
  input  logic [1:0]  avs_s1_address,
  input  logic        avs_s1_read,
  output logic [31:0] avs_s1_readdata,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic        ins_irq_irq,
  input  logic        vsync_pulse,
  output logic        fifo_flush,
  output logic [31:0] cam_address_top,
  output logic [15:0] cam_transcycle_num,
  output logic        cam_start,
  input  logic        cam_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_COMPLETE
  } state_t;

  state_t      state_q, state_d;
  logic        cont_q, cont_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_flag_q, irq_flag_d;
  logic        overrun_q, overrun_d;
  logic [25:0] buf_a_q, buf_a_d;
  logic [15:0] chunks_q, chunks_d;
  logic        fifo_flush_q, fifo_flush_d;
  logic        cam_start_q, cam_start_d;
  logic [25:0] cam_addr_q, cam_addr_d;
  logic [15:0] cam_len_q, cam_len_d;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
  logic [25:0] buf_b_q, buf_b_d;
  logic        buf_idx_q, buf_idx_d;
`endif

  logic wr_ctrl, wr_buf_a, wr_chunks, busy;
  logic unused_read;

  // Read data is a pure mux, so the read strobe carries no information.
  assign unused_read = avs_s1_read;

  assign wr_ctrl   = avs_s1_write && (avs_s1_address == 2'd0);
  assign wr_buf_a  = avs_s1_write && (avs_s1_address == 2'd1);
  assign wr_chunks = avs_s1_write && (avs_s1_address == 2'd3);
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    irq_en_d     = irq_en_q;
    irq_flag_d   = irq_flag_q;
    overrun_d    = overrun_q;
    buf_a_d      = buf_a_q;
    chunks_d     = chunks_q;
    fifo_flush_d = 1'b0;
    cam_start_d  = 1'b0;
    cam_addr_d   = cam_addr_q;
    cam_len_d    = cam_len_q;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
    buf_b_d      = buf_b_q;
    buf_idx_d    = buf_idx_q;
    if (avs_s1_write && (avs_s1_address == 2'd2)) buf_b_d = avs_s1_writedata[31:6];
`endif

    if (wr_ctrl) begin
      cont_d   = avs_s1_writedata[1];
      irq_en_d = avs_s1_writedata[2];
      if (avs_s1_writedata[9])  irq_flag_d = 1'b0;
      if (avs_s1_writedata[10]) overrun_d  = 1'b0;
    end
    if (wr_buf_a)  buf_a_d  = avs_s1_writedata[31:6];
    if (wr_chunks) chunks_d = avs_s1_writedata[15:0];

    // Hardware sets below come after the W1C clears so a same-cycle set wins.
    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && avs_s1_writedata[0] && (chunks_q != 16'd0)) state_d = S_ARM;
      end
      S_ARM: begin
        if (vsync_pulse) begin
          fifo_flush_d = 1'b1;
          cam_len_d    = chunks_q;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
          cam_addr_d   = buf_idx_q ? buf_b_q : buf_a_q;
`else
          cam_addr_d   = buf_a_q;
`endif
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cam_start_d = 1'b1;
        if (vsync_pulse) overrun_d = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (vsync_pulse) overrun_d = 1'b1;
        if (!cam_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (vsync_pulse) overrun_d = 1'b1;
        if (cam_done) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        irq_flag_d = 1'b1;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
        buf_idx_d  = ~buf_idx_q;
`endif
        state_d    = cont_q ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge avs_s1_clk or negedge csi_global_reset_n) begin
    if (!csi_global_reset_n) begin
      state_q      <= S_IDLE;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_flag_q   <= 1'b0;
      overrun_q    <= 1'b0;
      buf_a_q      <= '0;
      chunks_q     <= CHUNKS_DEFAULT;
      fifo_flush_q <= 1'b0;
      cam_start_q  <= 1'b0;
      cam_addr_q   <= '0;
      cam_len_q    <= '0;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
      buf_b_q      <= '0;
      buf_idx_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      irq_en_q     <= irq_en_d;
      irq_flag_q   <= irq_flag_d;
      overrun_q    <= overrun_d;
      buf_a_q      <= buf_a_d;
      chunks_q     <= chunks_d;
      fifo_flush_q <= fifo_flush_d;
      cam_start_q  <= cam_start_d;
      cam_addr_q   <= cam_addr_d;
      cam_len_q    <= cam_len_d;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
      buf_b_q      <= buf_b_d;
      buf_idx_q    <= buf_idx_d;
`endif
    end
  end

  always_comb begin
    avs_s1_readdata = '0;
    case (avs_s1_address)
      2'd0: begin
        avs_s1_readdata[1]  = cont_q;
        avs_s1_readdata[2]  = irq_en_q;
        avs_s1_readdata[8]  = busy;
        avs_s1_readdata[9]  = irq_flag_q;
        avs_s1_readdata[10] = overrun_q;
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
        avs_s1_readdata[11] = buf_idx_q;
`endif
      end
      2'd1: avs_s1_readdata = {buf_a_q, 6'b0};
`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
      2'd2: avs_s1_readdata = {buf_b_q, 6'b0};
`else
      2'd2: avs_s1_readdata = '0;
`endif
      default: avs_s1_readdata = {16'b0, chunks_q};
    endcase
  end

  assign ins_irq_irq        = irq_flag_q & irq_en_q;
  assign fifo_flush         = fifo_flush_q;
  assign cam_start          = cam_start_q;
  assign cam_address_top    = {cam_addr_q, 6'b0};
  assign cam_transcycle_num = cam_len_q;

endmodule

// File: tb/tb_peridot_cam_frame_seq.sv
// Bench for peridot_cam_frame_seq: launches are scoreboarded against expected {address, chunks}.
`timescale 1ns/1ps
module tb_peridot_cam_frame_seq;

`ifdef PERIDOT_CAM_SEQ_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        avs_s1_clk = 1'b0;
  logic        csi_global_reset_n = 1'b0;
  logic [1:0]  avs_s1_address = '0;
  logic        avs_s1_read = 1'b0;
  logic [31:0] avs_s1_readdata;
  logic        avs_s1_write = 1'b0;
  logic [31:0] avs_s1_writedata = '0;
  logic        ins_irq_irq;
  logic        vsync_pulse = 1'b0;
  logic        fifo_flush;
  logic [31:0] cam_address_top;
  logic [15:0] cam_transcycle_num;
  logic        cam_start;
  logic        cam_done;

  logic auto_master = 1'b0;
  logic mdl_done = 1'b1;
  logic man_done = 1'b1;
  assign cam_done = auto_master ? mdl_done : man_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];
  logic [31:0] r;

  peridot_cam_frame_seq dut (
    .avs_s1_clk         (avs_s1_clk),
    .csi_global_reset_n (csi_global_reset_n),
    .avs_s1_address     (avs_s1_address),
    .avs_s1_read        (avs_s1_read),
    .avs_s1_readdata    (avs_s1_readdata),
    .avs_s1_write       (avs_s1_write),
    .avs_s1_writedata   (avs_s1_writedata),
    .ins_irq_irq        (ins_irq_irq),
    .vsync_pulse        (vsync_pulse),
    .fifo_flush         (fifo_flush),
    .cam_address_top    (cam_address_top),
    .cam_transcycle_num (cam_transcycle_num),
    .cam_start          (cam_start),
    .cam_done           (cam_done)
  );

  always #5 avs_s1_clk = ~avs_s1_clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge avs_s1_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    avs_s1_address   = a;
    avs_s1_writedata = d;
    avs_s1_write     = 1'b1;
    tick();
    avs_s1_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    avs_s1_address = a;
    avs_s1_read    = 1'b1;
    #1;
    d = avs_s1_readdata;
    avs_s1_read    = 1'b0;
  endtask

  task automatic vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  // Polls one STAT bit until it reaches the wanted value or the budget runs out.
  task automatic wait_stat(input int b, input logic v, input int budget, input string tag);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < budget; i++) begin
      csr_rd(2'd0, d);
      if (d[b] === v) break;
      tick();
    end
    chk_eq(tag, 32'(d[b]), 32'(v));
  endtask

  task automatic do_reset();
    csi_global_reset_n = 1'b0;
    vsync_pulse  = 1'b0;
    avs_s1_write = 1'b0;
    man_done     = 1'b1;
    repeat (3) tick();
    csi_global_reset_n = 1'b1;
    tick();
  endtask

  // Scoreboard: every launch must match the oldest expected {address, chunks}.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge avs_s1_clk);
      if (cam_start === 1'b1) begin
        chk_eq("sb_expected_launch", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk_eq("launch_addr", cam_address_top, e[47:16]);
          chk_eq("launch_chunks", {16'h0, cam_transcycle_num}, {16'h0, e[15:0]});
        end
      end
    end
  end

  // Model burst master: goes busy two cycles after cam_start, idle again five cycles later.
  initial begin
    forever begin
      tick();
      if (auto_master && cam_start === 1'b1) begin
        repeat (2) tick();
        mdl_done = 1'b0;
        repeat (5) tick();
        mdl_done = 1'b1;
      end
    end
  end

  initial begin
    do_reset();

    chk_eq("rst_fifo_flush", 32'(fifo_flush), 32'd0);
    chk_eq("rst_cam_start", 32'(cam_start), 32'd0);
    chk_eq("rst_irq", 32'(ins_irq_irq), 32'd0);
    chk_eq("rst_cam_addr", cam_address_top, 32'd0);
    chk_eq("rst_cam_len", 32'(cam_transcycle_num), 32'd0);
    csr_rd(2'd0, r); chk_eq("rst_stat", r, 32'd0);
    csr_rd(2'd1, r); chk_eq("rst_buf_a", r, 32'd0);
    csr_rd(2'd3, r); chk_eq("rst_chunks", r, 32'd9600);

    // Single shot
    csr_wr(2'd1, 32'h1000_007F);
    csr_rd(2'd1, r); chk_eq("buf_a_lowbits", r, 32'h1000_0040);
    csr_wr(2'd3, 32'hFFFF_0004);
    csr_rd(2'd3, r); chk_eq("chunks_upper", r, 32'd4);
    csr_wr(2'd0, 32'h5);
    csr_rd(2'd0, r); chk_eq("ss_stat_armed", r, 32'h104);
    exp_q.push_back({32'h1000_0040, 16'd4});
    vsync();
    chk_eq("ss_flush_n1", 32'(fifo_flush), 32'd1);
    chk_eq("ss_addr_n1", cam_address_top, 32'h1000_0040);
    chk_eq("ss_len_n1", 32'(cam_transcycle_num), 32'd4);
    chk_eq("ss_start_n1", 32'(cam_start), 32'd0);
    tick();
    chk_eq("ss_start_n2", 32'(cam_start), 32'd1);
    chk_eq("ss_flush_n2", 32'(fifo_flush), 32'd0);
    tick();
    man_done = 1'b0;
    repeat (3) tick();
    man_done = 1'b1;
    tick();
    chk_eq("ss_irq_m1", 32'(ins_irq_irq), 32'd0);
    tick();
    chk_eq("ss_irq_m2", 32'(ins_irq_irq), 32'd1);
    csr_rd(2'd0, r); chk_eq("ss_stat_done", r, 32'h204 | (32'(PP) << 11));
    csr_wr(2'd0, 32'h204);
    chk_eq("ss_irq_w1c", 32'(ins_irq_irq), 32'd0);

    // Zero chunks must not arm
    csr_wr(2'd3, 32'd0);
    csr_wr(2'd0, 32'h5);
    csr_rd(2'd0, r); chk_eq("zero_busy", 32'(r[8]), 32'd0);
    vsync();
    repeat (4) tick();
    csr_rd(2'd0, r); chk_eq("zero_busy_after", 32'(r[8]), 32'd0);

    // Continuous ping-pong, cont cleared during frame 3
    do_reset();
    csr_wr(2'd1, 32'h100);
    csr_wr(2'd2, 32'h200);
    csr_wr(2'd3, 32'd8);
    auto_master = 1'b1;
    csr_wr(2'd0, 32'h3);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({((PP && i == 1) ? 32'h200 : 32'h100), 16'd8});
      vsync();
      if (i == 2) begin
        csr_wr(2'd0, 32'h0);
        wait_stat(8, 1'b0, 80, "cont_final_idle");
      end else begin
        wait_stat(9, 1'b1, 80, "cont_frame_irq");
        csr_rd(2'd0, r); chk_eq("cont_rearmed", 32'(r[8]), 32'd1);
        chk_eq("cont_irq_masked", 32'(ins_irq_irq), 32'd0);
        csr_wr(2'd0, 32'h202);
      end
    end
    csr_rd(2'd0, r); chk_eq("cont_stat_end", r, 32'h200 | (32'(PP) << 11));
    chk_eq("cont_irq_masked_end", 32'(ins_irq_irq), 32'd0);
    csr_rd(2'd2, r); chk_eq("buf_b_read", r, PP ? 32'h200 : 32'h0);
    auto_master = 1'b0;

    // Overrun: vsync during WAIT_DONE
    csr_wr(2'd0, 32'h204);
    csr_wr(2'd3, 32'd2);
    csr_wr(2'd0, 32'h5);
    exp_q.push_back({(PP ? 32'h200 : 32'h100), 16'd2});
    vsync();
    repeat (2) tick();
    man_done = 1'b0;
    repeat (2) tick();
    vsync();
    csr_rd(2'd0, r);
    chk_eq("ovr_set", 32'(r[10]), 32'd1);
    chk_eq("ovr_still_busy", 32'(r[8]), 32'd1);
    man_done = 1'b1;
    repeat (3) tick();
    csr_rd(2'd0, r);
    chk_eq("ovr_irq", 32'(r[9]), 32'd1);
    chk_eq("ovr_idle", 32'(r[8]), 32'd0);
    csr_wr(2'd0, 32'h404);
    csr_rd(2'd0, r);
    chk_eq("ovr_w1c", 32'(r[10]), 32'd0);
    chk_eq("ovr_irq_kept", 32'(r[9]), 32'd1);

    // W1C of irq_flag in the COMPLETE cycle: the set wins
    csr_wr(2'd0, 32'h204);
    csr_wr(2'd3, 32'd1);
    csr_wr(2'd0, 32'h5);
    exp_q.push_back({32'h100, 16'd1});
    vsync();
    repeat (2) tick();
    man_done = 1'b0;
    repeat (2) tick();
    man_done = 1'b1;
    tick();
    csr_wr(2'd0, 32'h204);
    csr_rd(2'd0, r); chk_eq("w1c_race_flag", 32'(r[9]), 32'd1);
    chk_eq("w1c_race_pin", 32'(ins_irq_irq), 32'd1);

    // Asynchronous reset while in WAIT_DONE
    csr_wr(2'd1, 32'h1234_5680);
    csr_wr(2'd3, 32'd16);
    csr_wr(2'd0, 32'h5);
    exp_q.push_back({(PP ? 32'h200 : 32'h1234_5680), 16'd16});
    vsync();
    repeat (2) tick();
    man_done = 1'b0;
    repeat (2) tick();
    chk_eq("pre_rst_len", 32'(cam_transcycle_num), 32'd16);
    chk_eq("pre_rst_irq", 32'(ins_irq_irq), 32'd1);
    #2;
    csi_global_reset_n = 1'b0;
    #1;
    chk_eq("arst_cam_addr", cam_address_top, 32'd0);
    chk_eq("arst_cam_len", 32'(cam_transcycle_num), 32'd0);
    chk_eq("arst_irq", 32'(ins_irq_irq), 32'd0);
    chk_eq("arst_start", 32'(cam_start), 32'd0);
    chk_eq("arst_flush", 32'(fifo_flush), 32'd0);
    csr_rd(2'd3, r); chk_eq("arst_chunks", r, 32'd9600);
    csr_rd(2'd0, r); chk_eq("arst_stat", r, 32'd0);
    man_done = 1'b1;
    tick();
    csi_global_reset_n = 1'b1;
    repeat (2) tick();

    chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
